galaxian_dl_ctrl: RTL
=====================

# galaxian_dl_ctrl

ROM download sequencer for the Galaxian-family core. It sits between `data_io` and the `galaxian` game block, in the 12 MHz domain. It decodes each downloaded byte into one of the four ROM regions and forwards it as a registered write strobe. It also owns the game reset: the core stays in reset until a complete image has loaded, and every reset lasts a guaranteed minimum time.

## Interface
Parameters:
- `HOLD_CYCLES`, default 1200: minimum number of clk_i cycles that `core_reset` stays high after a load or a user reset (100 µs at 12 MHz).
- `ROM_SIZE`, default 16'h6020: exact number of in-range bytes that makes up a complete image.
- `ROM_INDEX`, default 8'h00: `ioctl_index` value that identifies the ROM download.

Ports:
- `clk_i` in 1: system clock (clk_12); the only clock.
- `res_n_i` in 1: reset, synchronous, active-low.
- `ioctl_downl` in 1: download active, from `data_io`.
- `ioctl_index` in 8: download index.
- `ioctl_wr` in 1: one-cycle byte-write pulse.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `usr_rst` in 1: user reset request (status[0] | buttons[1]), level.
- `dl_wr` out 1: registered write strobe to the core.
- `dl_addr` out 16: registered write address.
- `dl_data` out 8: registered write data.
- `rom_cs` out 4: one-hot region select, valid while `dl_wr` is high.
  - bit0: PGM, 0000–3FFF.
  - bit1: 1K, 4000–4FFF.
  - bit2: 1H, 5000–5FFF.
  - bit3: 6L, 6000–601F.
- `core_reset` out 1: reset to the game core, active-high.
- `dl_busy` out 1: high in state LOAD.
- `err_short` out 1: last image was incomplete; sticky until the next ROM download starts.
- `err_ovf` out 1: a write with address ≥ ROM_SIZE was dropped; sticky until the next ROM download starts.

## Operation
- States: IDLE, LOAD, CHECK, HOLD, RUN, ERROR.
- IDLE:
  - Entered from reset; `core_reset`=1.
  - Goes to LOAD when `ioctl_downl`=1 and `ioctl_index`==ROM_INDEX.
- LOAD:
  - On entry, clears the byte counter (16-bit), `err_short` and `err_ovf`.
  - Each `ioctl_wr` with `ioctl_addr` < ROM_SIZE: forwards the write, increments the counter, sets the matching `rom_cs` bit.
  - Address ≥ ROM_SIZE, including any set bit in [24:16]: no `dl_wr`, sets `err_ovf`.
  - When `ioctl_downl` falls, goes to CHECK. A write in the same cycle as the fall is still accepted.
- CHECK (1 cycle):
  - Counter == ROM_SIZE: go to HOLD and load the hold counter with HOLD_CYCLES-1.
  - Otherwise: set `err_short` and go to ERROR.
- HOLD:
  - `core_reset`=1; the hold counter decrements each cycle.
  - At 0 the state goes to RUN.
  - `usr_rst` high reloads the counter, so the release comes HOLD_CYCLES after `usr_rst` falls.
- RUN:
  - `core_reset`=0.
  - `usr_rst`=1 goes to HOLD (counter reloaded).
  - A new ROM download goes to LOAD.
- ERROR:
  - `core_reset`=1; `usr_rst` is ignored.
  - Only a new ROM download, which goes to LOAD, leaves this state.
- A download with a different index is ignored in every state: no writes, no state change.
- `usr_rst` is ignored in LOAD, CHECK and IDLE.
- `core_reset` is 1 in every state except RUN.
- Counter arithmetic: 16-bit unsigned, saturates at FFFF. It can never exceed ROM_SIZE, because out-of-range writes are not counted.
- Duplicate addresses are counted again. Data_io addresses are strictly sequential, so an image with duplicates is treated as malformed.

## Timing
- Reset values:
  - state = IDLE.
  - `core_reset` = 1.
  - `dl_wr`, `dl_busy`, `err_short`, `err_ovf` = 0.
  - `rom_cs` = 0, `dl_addr` = 0, `dl_data` = 0.
- Reset mid-operation: `res_n_i` low forces the reset values on the next edge, regardless of state. An interrupted download therefore needs a fresh download.
- Write latency: 1 cycle. `ioctl_wr` at edge n gives `dl_wr`, `dl_addr`, `dl_data`, `rom_cs` at edge n+1, held for exactly 1 cycle.
- `dl_busy` rises 1 cycle after the qualifying `ioctl_downl` rise and falls 1 cycle after `ioctl_downl` falls.
- Release timing: in a successful load, `core_reset` falls exactly HOLD_CYCLES+1 cycles after the `ioctl_downl` fall is sampled (1 cycle CHECK + HOLD_CYCLES).
- Back-to-back `ioctl_wr` on consecutive cycles is supported; no throttling.

## Test plan
- Full image: download index 0 with 0x6020 sequential bytes.
  - 0x6020 `dl_wr` pulses.
  - Addr 0x3FFF has `rom_cs`=0001; 0x4000 has 0010; 0x5FFF has 0100; 0x601F has 1000.
  - `core_reset` falls 1201 cycles after the `ioctl_downl` fall; `err_*`=0.
- Short image: 0x6000 bytes → `err_short`=1, state ERROR, `core_reset` stays 1. A `usr_rst` pulse has no effect. A following full download clears `err_short` and releases reset.
- Overflow: 0x6021 bytes → the byte at 0x6020 produces no `dl_wr`; `err_ovf`=1, `err_short`=0, reset released normally.
- User reset in RUN: 5-cycle `usr_rst` pulse → `core_reset` rises on the next cycle and falls 1200 cycles after `usr_rst` falls.
- Foreign index: download index 1 while in RUN → no `dl_wr`, `core_reset` stays 0, `dl_busy`=0.
- Reset mid-load: `res_n_i`=0 after 0x100 bytes → all outputs at reset values next edge. A subsequent full download completes normally.

Source files
------------

// File: rtl/galaxian_dl_ctrl.sv
// ROM download sequencer: routes data_io bytes into the four ROM regions and
// holds the game core in reset until a complete image has loaded.
module galaxian_dl_ctrl #(
  parameter int          HOLD_CYCLES = 1200,
  parameter logic [15:0] ROM_SIZE    = 16'h6020,
  parameter logic [7:0]  ROM_INDEX   = 8'h00
) (
  input  logic        clk_i,
  input  logic        res_n_i,
  input  logic        ioctl_downl,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        usr_rst,
  output logic        dl_wr,
  output logic [15:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic [3:0]  rom_cs,
  output logic        core_reset,
  output logic        dl_busy,
  output logic        err_short,
  output logic        err_ovf
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_HOLD, S_RUN, S_ERROR} state_t;

  localparam int          HW          = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);

  state_t        r_state, w_next;
  logic [15:0]   r_cnt;
  logic [HW-1:0] r_hold;
  logic          r_dl_wr, r_core_reset, r_busy, r_err_short, r_err_ovf;
  logic [15:0]   r_dl_addr;
  logic [7:0]    r_dl_data;
  logic [3:0]    r_rom_cs;

  logic          w_rom_dl, w_in_range, w_accept, w_drop, w_enter_load, w_reload;
  logic [3:0]    w_cs;

  always_comb begin
    w_rom_dl     = ioctl_downl && (ioctl_index == ROM_INDEX);
    // Any set bit above bit 15 is out of range regardless of the low half.
    w_in_range   = (ioctl_addr[24:16] == 9'd0) && (ioctl_addr[15:0] < ROM_SIZE);
    w_accept     = (r_state == S_LOAD) && ioctl_wr && w_in_range;
    w_drop       = (r_state == S_LOAD) && ioctl_wr && !w_in_range;
    w_cs         = 4'b0000;
    if (ioctl_addr[15:0] < 16'h4000)      w_cs = 4'b0001;
    else if (ioctl_addr[15:12] == 4'h4)   w_cs = 4'b0010;
    else if (ioctl_addr[15:12] == 4'h5)   w_cs = 4'b0100;
    else if (ioctl_addr[15:12] == 4'h6)   w_cs = 4'b1000;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_rom_dl) w_next = S_LOAD;
      S_LOAD:  if (!ioctl_downl) w_next = S_CHECK;
      S_CHECK: w_next = (r_cnt == ROM_SIZE) ? S_HOLD : S_ERROR;
      S_HOLD:  if (!usr_rst && r_hold == '0) w_next = S_RUN;
      S_RUN: begin
        if (w_rom_dl)     w_next = S_LOAD;
        else if (usr_rst) w_next = S_HOLD;
      end
      S_ERROR: if (w_rom_dl) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
    w_enter_load = (w_next == S_LOAD) && (r_state != S_LOAD);
    // usr_rst keeps the hold counter pinned, so release is measured from its fall.
    w_reload     = ((r_state == S_CHECK) && (w_next == S_HOLD)) ||
                   (((r_state == S_HOLD) || (r_state == S_RUN)) && usr_rst);
  end

  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_hold       <= '0;
      r_dl_wr      <= 1'b0;
      r_dl_addr    <= '0;
      r_dl_data    <= '0;
      r_rom_cs     <= '0;
      r_core_reset <= 1'b1;
      r_busy       <= 1'b0;
      r_err_short  <= 1'b0;
      r_err_ovf    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_core_reset <= (w_next != S_RUN);
      r_busy       <= (w_next == S_LOAD);
      r_dl_wr      <= w_accept;
      r_rom_cs     <= w_accept ? w_cs : 4'b0000;
      if (w_accept) begin
        r_dl_addr <= ioctl_addr[15:0];
        r_dl_data <= ioctl_dout;
      end
      if (w_enter_load) begin
        r_cnt       <= '0;
        r_err_short <= 1'b0;
        r_err_ovf   <= 1'b0;
      end else begin
        if (w_accept && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
        if (w_drop) r_err_ovf <= 1'b1;
        if ((r_state == S_CHECK) && (r_cnt != ROM_SIZE)) r_err_short <= 1'b1;
      end
      if (w_reload)                                r_hold <= HOLD_RELOAD;
      else if (r_state == S_HOLD && r_hold != '0)  r_hold <= r_hold - 1'b1;
    end
  end

  assign dl_wr      = r_dl_wr;
  assign dl_addr    = r_dl_addr;
  assign dl_data    = r_dl_data;
  assign rom_cs     = r_rom_cs;
  assign core_reset = r_core_reset;
  assign dl_busy    = r_busy;
  assign err_short  = r_err_short;
  assign err_ovf    = r_err_ovf;

endmodule
